// File: rtl/hub75_frame_dma.sv
// hub75_frame_dma: copies one packed-RGB frame from memory into the HUB75 driver back buffer, then flips buffers on vsync.
// Latency: 3 cycles per master transfer with a 1-cycle slave (6 per pixel); slave register reads return the cycle after request.
// Backpressure: master strobes are held until m_ready, followed by one turnaround cycle; optional gamma via HUB75_DMA_GAMMA_EN.
module hub75_frame_dma #(
  parameter int          ROWS         = 64,
  parameter int          COLS         = 64,
  parameter logic [31:0] BASEADDR     = 32'h81100000,
  parameter logic [31:0] DRV_BASEADDR = 32'h81000000
) (
  input  logic        clk,
  input  logic        rst,
  // slave register bus
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  // master bus towards memory and the panel driver
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  output logic        m_wen,
  output logic        m_ren,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        irq
);

  localparam int          NPIX      = ROWS * COLS;
  localparam int          NW        = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [NW-1:0] LAST    = NW'(NPIX - 1);
  // driver control word sits just past both frame buffers
  localparam logic [31:0] CTRL_ADDR = DRV_BASEADDR + 32'(2 * NPIX * 4);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GETSEL = 3'd1;
  localparam logic [2:0] S_RD     = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_POLL   = 3'd4;
  localparam logic [2:0] S_SWAP   = 3'd5;

  logic [2:0]    state;
  logic          turn;      // 1 during the turnaround cycle after a completed transfer
  logic [NW-1:0] n;         // pixel index
  logic          back;      // back buffer selected for this frame
  logic [23:0]   pix;
  logic          vs;        // vsync bit captured by the last poll
  logic [31:0]   src_cur;   // SRC snapshot for the frame in flight
  logic [31:0]   src_reg;
  logic          cont;
  logic          done;
  logic [15:0]   frames;
  logic          busy;

  // ---------------- slave decode ----------------
  logic [31:0] off;
  logic        sel_src, sel_ctrl, sel_stat;
  logic        start_req, done_clr;

  assign off      = addr - BASEADDR;
  assign active   = (addr >= BASEADDR) && (off < 32'd12);
  assign sel_src  = active && (off[3:2] == 2'd0);
  assign sel_ctrl = active && (off[3:2] == 2'd1);
  assign sel_stat = active && (off[3:2] == 2'd2);

  assign start_req = wen && sel_ctrl && wmask[0] && wdata[0];
  assign done_clr  = wen && sel_stat && wmask[0] && wdata[1];
  assign busy      = (state != S_IDLE);
  assign irq       = done;

  logic unused_ok;
  assign unused_ok = &{1'b0, off[31:4], off[1:0], m_rdata[31:24]};

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  m);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

`ifdef HUB75_DMA_GAMMA_EN
  function automatic logic [7:0] gam(input logic [7:0] c);
    logic [15:0] p;
    p = {8'h00, c} * {8'h00, c};
    return p[15:8];
  endfunction
`endif

  // pixel data as it will be written, squared per channel when gamma is built in
  logic [23:0] pix_next;
`ifdef HUB75_DMA_GAMMA_EN
  assign pix_next = {gam(m_rdata[23:16]), gam(m_rdata[15:8]), gam(m_rdata[7:0])};
`else
  assign pix_next = m_rdata[23:0];
`endif

  // ---------------- address generation ----------------
  logic [NW-1:0] n_inc;
  logic [31:0]   pix_addr;
  logic [31:0]   rd_addr_next;

  assign n_inc        = n + NW'(1);
  assign pix_addr     = DRV_BASEADDR + (((back ? 32'(NPIX) : 32'd0) + 32'(n)) << 2);
  assign rd_addr_next = src_cur + (32'(n_inc) << 2);

  // Slave registers: SRC/CONT storage and registered read response
  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg <= 32'h0;
      cont    <= 1'b0;
      ready   <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      ready <= active && (ren || wen);
      if (wen && sel_src)
        src_reg <= lane_merge(src_reg, wdata, wmask) & 32'hFFFF_FFFC;
      if (wen && sel_ctrl && wmask[0])
        cont <= wdata[1];
      if (active && ren) begin
        case (off[3:2])
          2'd0:    rdata <= src_reg;
          2'd1:    rdata <= {30'h0, cont, 1'b0};
          default: rdata <= {frames, 14'h0, done, busy};
        endcase
      end else begin
        rdata <= 32'h0;
      end
    end
  end

  // Copy engine FSM: each bus state holds its strobe until m_ready, then spends one turnaround
  // cycle, at the end of which the next state's transfer is launched
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      turn    <= 1'b0;
      n       <= '0;
      back    <= 1'b0;
      pix     <= 24'h0;
      vs      <= 1'b0;
      src_cur <= 32'h0;
      m_addr  <= 32'h0;
      m_wdata <= 32'h0;
      m_wmask <= 4'h0;
      m_wen   <= 1'b0;
      m_ren   <= 1'b0;
      frames  <= 16'h0;
      done    <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        turn <= 1'b0;
        if (start_req) begin
          state   <= S_GETSEL;
          src_cur <= src_reg;
          m_addr  <= CTRL_ADDR;
          m_ren   <= 1'b1;
        end
      end else if (!turn) begin
        if (m_ready) begin
          m_wen <= 1'b0;
          m_ren <= 1'b0;
          turn  <= 1'b1;
          case (state)
            S_GETSEL: back <= ~m_rdata[0];
            S_RD:     pix  <= pix_next;
            S_POLL:   vs   <= m_rdata[8];
            default:  ;
          endcase
        end
      end else begin
        turn <= 1'b0;
        case (state)
          S_GETSEL: begin
            state  <= S_RD;
            n      <= '0;
            m_addr <= src_cur;
            m_ren  <= 1'b1;
          end
          S_RD: begin
            state   <= S_WR;
            m_addr  <= pix_addr;
            m_wdata <= {8'h00, pix};
            m_wmask <= 4'b0111;
            m_wen   <= 1'b1;
          end
          S_WR: begin
            if (n == LAST) begin
              state  <= S_POLL;
              m_addr <= CTRL_ADDR;
              m_ren  <= 1'b1;
            end else begin
              n      <= n_inc;
              state  <= S_RD;
              m_addr <= rd_addr_next;
              m_ren  <= 1'b1;
            end
          end
          S_POLL: begin
            if (vs) begin
              state   <= S_SWAP;
              m_addr  <= CTRL_ADDR;
              m_wdata <= {23'h0, 1'b1, 7'h0, back};
              m_wmask <= 4'b0011;
              m_wen   <= 1'b1;
            end else begin
              m_ren <= 1'b1;
            end
          end
          S_SWAP: begin
            frames <= frames + 16'd1;
            if (cont) begin
              state   <= S_GETSEL;
              src_cur <= src_reg;
              m_addr  <= CTRL_ADDR;
              m_ren   <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      // a completing swap takes priority over a simultaneous clear
      if (state == S_SWAP && turn)
        done <= 1'b1;
      else if (done_clr)
        done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hub75_frame_dma.sv
// tb_hub75_frame_dma: scoreboard bench for hub75_frame_dma with memory + driver bus model.
// Expected master writes and register reads are queued at stimulus time and checked by a monitor.
// Bus model answers with a registered ready (1-cycle latency) and can be stalled.
module tb_hub75_frame_dma;

  localparam logic [31:0] BASE  = 32'h81100000;
  localparam logic [31:0] R_SRC = 32'h81100000;
  localparam logic [31:0] R_CTL = 32'h81100004;
  localparam logic [31:0] R_STA = 32'h81100008;
  localparam logic [31:0] DRV   = 32'h81000000;
  localparam logic [31:0] DCTL  = 32'h81008000;
  localparam logic [31:0] SRC_A = 32'h00001000;
  localparam logic [31:0] SRC_B = 32'h00020000;
`ifdef HUB75_DMA_GAMMA_EN
  localparam logic [31:0] B0_EXP = 32'h00FE4001;
  localparam logic [31:0] BN_EXP = 32'h00010040;
`else
  localparam logic [31:0] B0_EXP = 32'h00FF8010;
  localparam logic [31:0] BN_EXP = 32'h00100080;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;
  logic        wen, ren, ready, active;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;
  logic        m_wen, m_ren, m_ready, irq;

  hub75_frame_dma dut (
    .clk(clk), .rst(rst),
    .addr(addr), .wdata(wdata), .wmask(wmask), .wen(wen), .ren(ren),
    .rdata(rdata), .ready(ready), .active(active),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wen(m_wen), .m_ren(m_ren),
    .m_rdata(m_rdata), .m_ready(m_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0;
  int n_ctl_rd = 0;
  logic [67:0] exp_q[$];
  logic [31:0] rd_q[$];
  logic        ren_q = 1'b0;

  // bus model state
  logic stall = 1'b0;
  logic vs_force = 1'b0;
  logic drv_rst = 1'b1;
  logic drv_sel = 1'b0;
  logic drv_vs = 1'b0;

  task automatic check(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a >= SRC_A && a < SRC_A + 32'h4000) return (a - SRC_A) >> 2;
    if (a == SRC_B) return 32'h00FF8010;
    if (a > SRC_B && a < SRC_B + 32'h4000) return 32'h00100080;
    return 32'hDEADBEEF;
  endfunction

  // memory + driver model: registered ready, driver control word with W1C vsync
  always @(posedge clk) begin
    m_ready <= (m_wen || m_ren) && !stall;
    if (m_ren) m_rdata <= (m_addr == DCTL) ? {23'h0, drv_vs, 7'h0, drv_sel} : mem_rd(m_addr);
    if (drv_rst) begin
      drv_sel <= 1'b0;
      drv_vs  <= 1'b0;
    end else if (m_wen && m_ready && m_addr == DCTL) begin
      if (m_wmask[0]) drv_sel <= m_wdata[0];
      if (m_wmask[1] && m_wdata[8]) drv_vs <= 1'b0;
    end else if (vs_force) begin
      drv_vs <= 1'b1;
    end
    ren_q <= ren;
  end

  // monitor: accepted master writes and slave read responses against the scoreboard
  always @(negedge clk) begin
    if (!rst && m_wen && m_ready) begin
      n_wr++;
      if (exp_q.size() == 0) check("unexpected_wr", {m_addr, m_wdata, m_wmask}, 68'h0);
      else check("m_write", {m_addr, m_wdata, m_wmask}, exp_q.pop_front());
    end
    if (!rst && m_ren && m_ready && m_addr == DCTL) n_ctl_rd++;
    if (ready && ren_q) begin
      if (rd_q.size() == 0) check("unexpected_rd", {36'h0, rdata}, 68'h0);
      else check("reg_read", {36'h0, rdata}, {36'h0, rd_q.pop_front()});
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr = a; wdata = d; wmask = m; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0; addr = 32'h0;
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] e);
    rd_q.push_back(e);
    @(negedge clk);
    addr = a; ren = 1'b1;
    @(negedge clk);
    ren = 1'b0; addr = 32'h0;
  endtask

  task automatic push_frame(input logic back, input logic use_b);
    for (int i = 0; i < 4096; i++) begin
      logic [31:0] d;
      if (use_b) d = (i == 0) ? B0_EXP : BN_EXP;
      else d = i;
      exp_q.push_back({DRV + ((back ? 32'd4096 : 32'd0) + i) * 4, d, 4'b0111});
    end
    exp_q.push_back({DCTL, 31'h80, back, 4'b0011});
  endtask

  task automatic wait_wr(input int target, input int budget, input string nm);
    int c = 0;
    while (n_wr < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(nm, n_wr >= target, 1);
  endtask

  int base, ctl0, act_cnt;

  initial begin
    rst = 1'b1; addr = 0; wdata = 0; wmask = 0; wen = 0; ren = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_wen", m_wen, 0);
    check("rst_m_ren", m_ren, 0);
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", irq, 0);
    check("rst_m_addr", {m_addr, m_wdata, m_wmask}, 0);
    rst = 1'b0; drv_rst = 1'b0;
    expect_read(R_STA, 32'h0);
    expect_read(R_CTL, 32'h0);
    addr = BASE + 32'd12; #1 check("active_above", active, 0);
    addr = R_STA;         #1 check("active_stat", active, 1);
    addr = 32'h0;

    // ---- single frame, vsync held low after the copy ----
    bus_write(R_SRC, SRC_A, 4'hF);
    push_frame(1'b1, 1'b0);
    base = n_wr;
    bus_write(R_CTL, 32'h1, 4'hF);
    expect_read(R_CTL, 32'h0);
    wait_wr(base + 4096, 30000, "frame1_copy_timeout");
    ctl0 = n_ctl_rd;
    repeat (500) @(negedge clk);
    check("no_swap_before_vsync", n_wr, base + 4096);
    check("polls_during_wait", (n_ctl_rd - ctl0) > 100, 1);
    vs_force = 1'b1;
    wait_wr(base + 4097, 100, "swap_timeout");
    repeat (3) @(negedge clk);
    check("irq_after_frame", irq, 1);
    expect_read(R_STA, 32'h00010002);
    vs_force = 1'b0;
    // done W1C and masked SRC write
    bus_write(R_STA, 32'h2, 4'h1);
    expect_read(R_STA, 32'h00010000);
    check("irq_cleared", irq, 0);
    bus_write(R_SRC, 32'hAABBCC03, 4'b0101);
    expect_read(R_SRC, 32'h00BB1000);

    // ---- reset while a pixel write is stalled ----
    bus_write(R_SRC, SRC_A, 4'hF);
    bus_write(R_CTL, 32'h1, 4'hF);
    act_cnt = 0;
    while (!m_wen && act_cnt < 200) begin @(negedge clk); act_cnt++; end
    check("first_wr_seen", m_wen, 1);
    stall = 1'b1;
    repeat (5) @(negedge clk);
    check("wr_held_stalled", m_wen, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drops_wen", m_wen, 0);
    check("rst_drops_ren", m_ren, 0);
    rst = 1'b0; stall = 1'b0;
    act_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_wen || m_ren) act_cnt++;
    end
    check("no_bus_after_rst", act_cnt, 0);
    expect_read(R_STA, 32'h0);

    // ---- continuous mode, SRC change and CONT clear during frame 2 ----
    drv_rst = 1'b1; @(negedge clk); drv_rst = 1'b0;
    vs_force = 1'b1;
    bus_write(R_SRC, SRC_A, 4'hF);
    push_frame(1'b1, 1'b0);
    push_frame(1'b0, 1'b1);
    base = n_wr;
    bus_write(R_CTL, 32'h3, 4'hF);
    bus_write(R_SRC, SRC_B | 32'h3, 4'hF);
    expect_read(R_SRC, SRC_B);
    expect_read(R_STA, 32'h00000001);
    wait_wr(base + 4097 + 20, 30000, "cont_frame1_timeout");
    bus_write(R_CTL, 32'h0, 4'hF);
    expect_read(R_CTL, 32'h0);
    wait_wr(base + 8194, 30000, "cont_frame2_timeout");
    repeat (5) @(negedge clk);
    expect_read(R_STA, 32'h00020002);
    act_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_wen || m_ren) act_cnt++;
    end
    check("idle_after_cont", act_cnt, 0);
    check("swap_count", n_wr - base, 8194);
    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
